// File: rtl/cla5_mp_seq_if.sv
// Request/adder bundle for the multi-precision CLA sequencer.
// The slave side is the sequencer; the master side is the requester plus the external 5-bit adder.
interface cla5_mp_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 5 * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic [4:0]   add_a;
  logic [4:0]   add_b;
  logic         add_cin;
  logic [4:0]   add_s;
  logic         add_cout;

  modport master (
    output start, sub, op_a, op_b, add_s, add_cout,
    input  busy, done, result, carry_out, overflow, add_a, add_b, add_cin
  );

  modport slave (
    input  start, sub, op_a, op_b, add_s, add_cout,
    output busy, done, result, carry_out, overflow, add_a, add_b, add_cin
  );
endinterface

// File: rtl/cla5_mp_seq.sv
// Multi-precision add/subtract sequencer: streams 5-bit chunks, LSB first, through
// one external combinational CLA and chains the carry through a register.
module cla5_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cla5_mp_seq_if.slave  bus
);
  localparam int W    = 5 * WORDS;
  localparam int IDXW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [IDXW-1:0] idx_reg;
  logic [W-1:0]    ra_reg;
  logic [W-1:0]    rb_reg;
  logic [W-1:0]    result_reg;
  logic            carry_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            carry_out_reg;
  logic            overflow_reg;

  logic [4:0] a_chunk [WORDS];
  logic [4:0] b_chunk [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_chunk
      assign a_chunk[gi] = ra_reg[5*gi +: 5];
      assign b_chunk[gi] = rb_reg[5*gi +: 5];
    end
  endgenerate

  // The adder only sees live operands while running; otherwise it is parked at zero.
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state_reg == RUN) begin
      bus.add_a   = a_chunk[idx_reg];
      bus.add_b   = b_chunk[idx_reg];
      bus.add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      ra_reg        <= '0;
      rb_reg        <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
            ra_reg    <= bus.op_a;
            rb_reg    <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.sub;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          result_reg[5*idx_reg +: 5] <= bus.add_s;
          carry_reg                  <= bus.add_cout;
          if (idx_reg == IDXW'(WORDS - 1)) begin
            // The top chunk lands this edge, so its sign comes straight from the adder.
            carry_out_reg <= bus.add_cout;
            overflow_reg  <= (ra_reg[W-1] == rb_reg[W-1]) & (bus.add_s[4] != ra_reg[W-1]);
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_cla5_mp_seq.sv
// Directed bench for cla5_mp_seq with a behavioural 5-bit adder and result/chunk scoreboards.
module tb_cla5_mp_seq;
  localparam int WORDS = 4;
  localparam int W     = 5 * WORDS;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic       cin;
  } chunk_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla5_mp_seq_if #(.WORDS(WORDS)) bif ();

  // External combinational CLA stand-in.
  assign {bif.add_cout, bif.add_s} = 6'(bif.add_a) + 6'(bif.add_b) + 6'(bif.add_cin);

  cla5_mp_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  exp_t   exp_q   [$];
  chunk_t chunk_q [$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome from arithmetic definitions, plus the chunk stream the adder should see.
  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t       e;
    chunk_t     ch;
    logic [W:0] sum;
    logic [W-1:0] bb;
    logic [5:0] cs;
    logic       c;
    if (!s) begin
      sum    = {1'b0, a} + {1'b0, b};
      e.res  = sum[W-1:0];
      e.cout = sum[W];
      e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    end else begin
      e.res  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    end
    exp_q.push_back(e);
    bb = s ? ~b : b;
    c  = s;
    for (int i = 0; i < WORDS; i++) begin
      ch.a   = a[5*i +: 5];
      ch.b   = bb[5*i +: 5];
      ch.cin = c;
      chunk_q.push_back(ch);
      cs = 6'(ch.a) + 6'(ch.b) + 6'(c);
      c  = cs[5];
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit glitch, input bit hold, output int done_cyc);
    exp_t   e;
    chunk_t ch;
    int     k;
    e = '0;
    bif.op_a  = a;
    bif.op_b  = b;
    bif.sub   = s;
    bif.start = 1'b1;
    push_op(a, b, s);
    $display("op: a=%05h b=%05h sub=%0d glitch=%0d hold=%0d at cycle %0d", a, b, s, glitch, hold, cyc);
    tick();
    if (!hold) bif.start = 1'b0;
    k = 1;
    while (!bif.done && k < 3 * WORDS) begin
      if (chunk_q.size() > 0) begin
        ch = chunk_q.pop_front();
        chk("add_a_chunk",   32'(bif.add_a),   32'(ch.a));
        chk("add_b_chunk",   32'(bif.add_b),   32'(ch.b));
        chk("add_cin_chunk", 32'(bif.add_cin), 32'(ch.cin));
      end
      chk("busy_run", 32'(bif.busy), 32'd1);
      if (glitch && k == 2) begin
        bif.start = 1'b1;
        bif.op_a  = ~a;
        bif.op_b  = 20'h13579;
        bif.sub   = ~s;
      end
      tick();
      k++;
      if (glitch) bif.start = 1'b0;
    end
    chk("latency", 32'(k), 32'(WORDS + 1));
    chk("done_pulse_hi", 32'(bif.done), 32'd1);
    chk("chunks_consumed", 32'(chunk_q.size()), 32'd0);
    chunk_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result",    32'(bif.result),    32'(e.res));
      chk("carry_out", 32'(bif.carry_out), 32'(e.cout));
      chk("overflow",  32'(bif.overflow),  32'(e.ovf));
      chk("busy_done", 32'(bif.busy),      32'd1);
    end else begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end
    done_cyc = cyc;
    if (glitch) begin
      bif.start = 1'b1;
      bif.op_a  = 20'h0BEEF;
      bif.op_b  = 20'h0CAFE;
    end
    tick();
    if (glitch) bif.start = 1'b0;
    chk("done_pulse_lo", 32'(bif.done),   32'd0);
    chk("busy_idle",     32'(bif.busy),   32'd0);
    chk("add_a_idle",    32'(bif.add_a),  32'd0);
    chk("result_hold",   32'(bif.result), 32'(e.res));
    if (glitch) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("no_extra_done", 32'(bif.done),   32'd0);
        chk("no_restart",    32'(bif.busy),   32'd0);
        chk("result_kept",   32'(bif.result), 32'(e.res));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, d2, dx;
    bif.start = 1'b0;
    bif.sub   = 1'b0;
    bif.op_a  = '0;
    bif.op_b  = '0;

    tick();
    tick();
    chk("rst_busy",      32'(bif.busy),      32'd0);
    chk("rst_done",      32'(bif.done),      32'd0);
    chk("rst_result",    32'(bif.result),    32'd0);
    chk("rst_carry_out", 32'(bif.carry_out), 32'd0);
    chk("rst_overflow",  32'(bif.overflow),  32'd0);
    chk("rst_add_a",     32'(bif.add_a),     32'd0);
    chk("rst_add_b",     32'(bif.add_b),     32'd0);
    chk("rst_add_cin",   32'(bif.add_cin),   32'd0);
    rst_n = 1'b1;
    tick();

    run_op(20'h00001, 20'hFFFFF, 1'b0, 1'b0, 1'b0, dx);
    run_op(20'h00005, 20'h00007, 1'b1, 1'b0, 1'b0, dx);
    run_op(20'h7FFFF, 20'h00001, 1'b0, 1'b0, 1'b0, dx);
    run_op(20'h80000, 20'h00001, 1'b1, 1'b0, 1'b0, dx);
    run_op(20'hFFFF0, 20'h00020, 1'b0, 1'b1, 1'b0, dx);

    // Abort mid-operation with idx at 2.
    bif.op_a  = 20'h0AAAA;
    bif.op_b  = 20'h05555;
    bif.sub   = 1'b0;
    bif.start = 1'b1;
    $display("op: a=%05h b=%05h sub=0 aborted by reset at cycle %0d", bif.op_a, bif.op_b, cyc);
    tick();
    bif.start = 1'b0;
    tick();
    tick();
    chk("busy_before_abort", 32'(bif.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",      32'(bif.busy),      32'd0);
    chk("abort_result",    32'(bif.result),    32'd0);
    chk("abort_carry_out", 32'(bif.carry_out), 32'd0);
    chk("abort_done",      32'(bif.done),      32'd0);
    tick();
    tick();
    chk("abort_no_done", 32'(bif.done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_abort_done", 32'(bif.done), 32'd0);
    chk("post_abort_busy", 32'(bif.busy), 32'd0);
    run_op(20'h12345, 20'h11111, 1'b0, 1'b0, 1'b0, dx);

    // Back-to-back with start held high.
    run_op(20'h2468A, 20'h13579, 1'b0, 1'b0, 1'b1, d0);
    run_op(20'h2468A, 20'h13579, 1'b0, 1'b0, 1'b1, d1);
    run_op(20'h2468A, 20'h13579, 1'b0, 1'b0, 1'b1, d2);
    bif.start = 1'b0;
    chk("repeat_period_1", 32'(d1 - d0), 32'(WORDS + 2));
    chk("repeat_period_2", 32'(d2 - d1), 32'(WORDS + 2));
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla5_mp_seq.md
Name: cla5_mp_seq

Overview:
- Multi-precision add/subtract sequencer built around the shared 5-bit carry-lookahead adder.
- Splits two (5*WORDS)-bit operands into 5-bit chunks and feeds them through the external adder one chunk per cycle, LSB first.
- Chains the carry through a register and assembles the wide result.
- Sits between a requesting datapath (start/done handshake) and a single combinational 5-bit CLA instance.

Parameters:
- WORDS, 4, number of 5-bit chunks; operand width W = 5*WORDS; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A-B; sampled with start
- op_a  input  W  operand A; sampled with start
- op_b  input  W  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result, carry_out and overflow valid
- result  output  W  sum/difference register
- carry_out  output  1  final carry (for sub: 1 = no borrow)
- overflow  output  1  two's-complement overflow of the W-bit operation
- add_a  output  5  to adder A
- add_b  output  5  to adder B
- add_cin  output  1  to adder Cin
- add_s  input  5  from adder S
- add_cout  input  1  from adder Cout

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - busy, done, result, carry_out, overflow, and the internal idx, carry and operand registers all 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - add_a, add_b and add_cin driven to 0.
  - If start = 1 at a clock edge: latch op_a into ra. Latch op_b into rb, bitwise inverted when sub = 1. Latch sub into rsub. Set carry <= sub and idx <= 0. Go to RUN.
- RUN:
  - Combinational drive: add_a = ra[5*idx+4 : 5*idx], add_b = rb[5*idx+4 : 5*idx], add_cin = carry.
  - At each edge: result[5*idx+4 : 5*idx] <= add_s, carry <= add_cout.
  - If idx == WORDS-1, go to DONE; else idx <= idx+1.
- DONE:
  - done = 1 for exactly this cycle.
  - carry_out = registered carry.
  - overflow = (ra[W-1] == rb[W-1]) & (result[W-1] != ra[W-1]), where rb is the post-inversion value.
  - Unconditionally return to IDLE.
- Latency: start edge to done = WORDS+1 cycles. Minimum repeat period = WORDS+2 cycles (start held high is re-accepted in the IDLE cycle after DONE).
- start in RUN or DONE is ignored; latched operands and sub are unaffected. Changes to op_a, op_b or sub after acceptance have no effect.
- result changes chunk-by-chunk during RUN and is valid only when done = 1 or when busy = 0 after a completed operation.
- result, carry_out and overflow hold until the next accepted start.
- carry_out and overflow are registered, updated on the RUN→DONE edge, and stable through DONE and IDLE.
- Adder is assumed purely combinational with settled output within one cycle. The controller adds no bypass or pipelining.
- idx is wide enough for WORDS-1 and never wraps past WORDS-1.

Test Plan:
1. WORDS=4, add 0x00001 + 0xFFFFF → done at 5th edge after start; result = 0x00000, carry_out = 1, overflow = 0.
2. Subtract 0x00005 − 0x00007 → result = 0xFFFFE, carry_out = 0, overflow = 0. Check add_cin = 1 in the first RUN cycle and that add_b is the inverted chunk.
3. Add 0x7FFFF + 0x00001 → result = 0x80000, overflow = 1, carry_out = 0. Then subtract 0x80000 − 0x00001 → result = 0x7FFFF, overflow = 1.
4. Pulse start with different operands in RUN cycle 2 and in DONE → ignored; result is that of the first request; exactly one done pulse.
5. Assert rst_n = 0 mid-RUN (idx = 2) → busy, result and carry_out go to 0 asynchronously; no done. After release, add 0x12345 + 0x11111 → 0x23456.
6. Hold start = 1 continuously with fixed operands → done pulses every 6 cycles. Check chunk order LSB first on add_a/add_b against the scoreboard each cycle.
